// File: rtl/seg_scan.sv
// seg_scan: signed binary to BCD (double-dabble) display driver with leading-zero
// blanking, minus sign, decimal point and time-multiplexed digit scanning.
module seg_scan #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [WIDTH-1:0]  iVALUE,
    input  logic [2:0]        iDP,
    input  logic              iLOAD,
    output logic [5:0]        oNUM,
    output logic [DIGITS-1:0] oDIG,
    output logic              oBUSY,
    output logic              oOVF
);

    // The BCD register is widened when the magnitude can exceed the panel, so overflow is visible.
    localparam int BCD_N = (DIGITS > (WIDTH + 2) / 3) ? DIGITS : (WIDTH + 2) / 3;
    localparam int BCD_W = 4 * BCD_N;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [SCW-1:0]   SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, ABS, SHIFT, FORMAT} state_t;

    state_t                  state_r, state_nx_s;
    logic [WIDTH-1:0]        value_r, mag_r;
    logic [2:0]              dp_r;
    logic                    sign_r;
    logic [BCD_W-1:0]        bcd_r, bcd_adj_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [6*DIGITS-1:0]     code_r, code_nx_s;
    logic [DIGITS-1:0]       en_r, en_nx_s, odig_r;
    logic                    ovf_r, busy_r;
    logic [SCW-1:0]          scan_cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [5:0]              onum_r;
    logic [7:0]              nz_s, keep_s, dpm1_s;
    logic                    high_s, neg_s, ovf_s;

    assign oNUM  = onum_r;
    assign oDIG  = odig_r;
    assign oBUSY = busy_r;
    assign oOVF  = ovf_r;

    // FSM state register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_r <= IDLE;
        else      state_r <= state_nx_s;
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = iLOAD ? ABS : IDLE;
            ABS:     state_nx_s = SHIFT;
            SHIFT:   state_nx_s = (cnt_r == CNT_LAST) ? FORMAT : SHIFT;
            FORMAT:  state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Add-3 correction of every nibble ahead of the shift
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < BCD_N; i++) begin
            bcd_adj_s[4*i +: 4] = (bcd_r[4*i +: 4] >= 4'd5) ? bcd_r[4*i +: 4] + 4'd3
                                                             : bcd_r[4*i +: 4];
        end
    end

    // Blanking, sign placement, point and overflow from the finished BCD value
    always_comb begin
        nz_s   = 8'd0;
        high_s = 1'b0;
        for (int i = 0; i < BCD_N; i++) begin
            nz_s   = (bcd_r[4*i +: 4] != 4'd0) ? 8'(i) : nz_s;
            high_s = high_s | ((i >= DIGITS) && (bcd_r[4*i +: 4] != 4'd0));
        end
        dpm1_s = {5'd0, dp_r} - 8'd1;
        keep_s = ((dp_r != 3'd0) && (dpm1_s > nz_s)) ? dpm1_s : nz_s;
        neg_s  = sign_r & (bcd_r != {BCD_W{1'b0}});
        ovf_s  = high_s | (neg_s & (keep_s >= 8'(DIGITS - 1)));
        code_nx_s = {(6*DIGITS){1'b0}};
        en_nx_s   = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_s || (neg_s && (keep_s + 8'd1 == 8'(i)))) begin
                code_nx_s[6*i +: 6] = 6'd10;
            end else begin
                code_nx_s[6*i +: 6] = {2'b00, bcd_r[4*i +: 4]}
                    + (((dp_r != 3'd0) && (dpm1_s == 8'(i))) ? 6'd16 : 6'd0);
            end
            en_nx_s[i] = ovf_s | (keep_s >= 8'(i)) | (neg_s && (keep_s + 8'd1 == 8'(i)));
        end
    end

    // Conversion datapath and double-buffered display registers
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            value_r <= {WIDTH{1'b0}};
            dp_r    <= 3'd0;
            sign_r  <= 1'b0;
            mag_r   <= {WIDTH{1'b0}};
            bcd_r   <= {BCD_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            code_r  <= {(6*DIGITS){1'b0}};
            en_r    <= DIGITS'(1);
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (iLOAD) begin
                        value_r <= iVALUE;
                        dp_r    <= iDP;
                    end
                end
                ABS: begin
                    sign_r <= value_r[WIDTH-1];
                    mag_r  <= value_r[WIDTH-1] ? (~value_r + {{(WIDTH-1){1'b0}}, 1'b1}) : value_r;
                    bcd_r  <= {BCD_W{1'b0}};
                    cnt_r  <= {CNT_W{1'b0}};
                end
                SHIFT: begin
                    bcd_r <= {bcd_adj_s[BCD_W-2:0], mag_r[WIDTH-1]};
                    mag_r <= {mag_r[WIDTH-2:0], 1'b0};
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                FORMAT: begin
                    code_r <= code_nx_s;
                    en_r   <= en_nx_s;
                    ovf_r  <= ovf_s;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan: dwell counter, digit index and registered panel outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            scan_cnt_r <= {SCW{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            onum_r     <= 6'd0;
            odig_r     <= DIGITS'(1);
        end else begin
            if (scan_cnt_r == SCAN_LAST) begin
                scan_cnt_r <= {SCW{1'b0}};
                idx_r      <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end else begin
                scan_cnt_r <= scan_cnt_r + SCW'(1);
            end
            onum_r <= code_r[6*idx_r +: 6];
            odig_r <= en_r[idx_r] ? (DIGITS'(1) << idx_r) : {DIGITS{1'b0}};
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scoreboard bench for seg_scan; expected frames come from a
// decimal-arithmetic reference model and are compared against the scanned panel outputs.
module tb_seg_scan;
    localparam int WIDTH = 16, DIGITS = 6, SCAN_DIV = 4;

    logic        iCLK = 1'b0, iRST = 1'b1;
    logic [15:0] iVALUE = 16'd0;
    logic [2:0]  iDP = 3'd0;
    logic        iLOAD = 1'b0, iLOAD4 = 1'b0;
    logic [5:0]  oNUM, num4;
    logic [5:0]  oDIG;
    logic [3:0]  dig4;
    logic        oBUSY, oOVF, busy4, ovf4;

    seg_scan #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_dut (
        .iCLK(iCLK), .iRST(iRST), .iVALUE(iVALUE), .iDP(iDP), .iLOAD(iLOAD),
        .oNUM(oNUM), .oDIG(oDIG), .oBUSY(oBUSY), .oOVF(oOVF));

    seg_scan #(.WIDTH(WIDTH), .DIGITS(4), .SCAN_DIV(SCAN_DIV)) u_dut4 (
        .iCLK(iCLK), .iRST(iRST), .iVALUE(iVALUE), .iDP(iDP), .iLOAD(iLOAD4),
        .oNUM(num4), .oDIG(dig4), .oBUSY(busy4), .oOVF(ovf4));

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [35:0] codes;
        logic [5:0]  en;
        logic        ovf;
    } disp_t;

    disp_t exp_q[$];
    disp_t cur;
    int    checks = 0, fails = 0;
    int    k = 0;
    int    free_at = 0;
    logic  busy_prev = 1'b0;
    int    busy_len = 0;
    int    mon_s;

    // edges since reset release; the scanned slot follows from this alone
    always @(posedge iCLK or posedge iRST) begin
        if (iRST) k <= 0;
        else      k <= k + 1;
    end

    function automatic int slot_of(int kk, int d);
        return (kk == 0) ? 0 : ((kk - 1) / SCAN_DIV) % d;
    endfunction

    function automatic disp_t reset_disp();
        disp_t r;
        r = '0;
        r.en = 6'b000001;
        return r;
    endfunction

    function automatic disp_t model(int val, int dp, int d);
        disp_t r;
        int    mag, m0, nz, keep, lim, code;
        int    dig[8];
        bit    neg, ovf;
        r   = '0;
        neg = (val < 0);
        m0  = neg ? -val : val;
        mag = m0;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        nz = 0;
        for (int i = 0; i < 8; i++) begin
            dig[i] = mag % 10;
            mag    = mag / 10;
            if (dig[i] != 0) nz = i;
        end
        keep = (dp - 1 > nz) ? dp - 1 : nz;
        ovf  = (m0 >= lim) || (neg && (keep + 1 > d - 1));
        for (int i = 0; i < d; i++) begin
            if (ovf) begin
                code = 10;
                r.en[i] = 1'b1;
            end else begin
                code = dig[i] + ((dp != 0 && i == dp - 1) ? 16 : 0);
                r.en[i] = (i <= keep);
                if (neg && i == keep + 1) begin
                    code = 10;
                    r.en[i] = 1'b1;
                end
            end
            r.codes[6*i +: 6] = 6'(code);
        end
        r.ovf = ovf;
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    initial cur = reset_disp();

    // monitor: compares the scanned panel against the current expected frame
    always @(negedge iCLK) begin
        if (iRST) begin
            cur       = reset_disp();
            busy_prev = 1'b0;
            busy_len  = 0;
        end else begin
            mon_s = slot_of(k, DIGITS);
            if (cur.en[mon_s]) check("oNUM", oNUM, cur.codes[6*mon_s +: 6]);
            check("oDIG", oDIG, cur.en[mon_s] ? (1 << mon_s) : 0);
            if (oBUSY) busy_len++;
            if (busy_prev && !oBUSY) begin
                check("busy_len", busy_len, 18);
                busy_len = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL completion: got a conversion end, expected none");
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            check("oOVF", oOVF, cur.ovf);
            busy_prev = oBUSY;
        end
    end

    task automatic cyc(input bit ld, input int val, input int dp);
        @(negedge iCLK);
        iLOAD  = ld;
        iLOAD4 = 1'b0;
        iVALUE = 16'(val);
        iDP    = 3'(dp);
        if (ld && (k + 1) >= free_at) begin
            exp_q.push_back(model(val, dp, DIGITS));
            free_at = k + 1 + 19;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, int'($signed(iVALUE)), int'(iDP));
    endtask

    initial begin
        disp_t e4;
        int    s4, val, dp;
        repeat (2) @(posedge iCLK);
        #2 iRST = 1'b0;
        @(negedge iCLK);
        check("rst_oDIG", oDIG, 1);
        check("rst_oNUM", oNUM, 0);
        check("rst_oBUSY", oBUSY, 0);
        check("rst_oOVF", oOVF, 0);
        check("rst_dig4", dig4, 1);

        cyc(1'b1, 1234, 0);  idle(45);
        cyc(1'b1, -5, 3);    idle(45);

        cyc(1'b1, -32768, 0);
        iLOAD4 = 1'b1;
        idle(22);
        e4 = model(-32768, 0, 4);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, -32768, 0);
            s4 = slot_of(k, 4);
            check("ovf4", ovf4, e4.ovf);
            check("num4", num4, e4.codes[6*s4 +: 6]);
            check("dig4", dig4, e4.en[s4] ? (1 << s4) : 0);
        end
        idle(10);

        cyc(1'b1, 777, 2);  idle(4);
        cyc(1'b1, 9999, 0); idle(50);
        cyc(1'b1, 42, 1); cyc(1'b1, 42, 1); cyc(1'b1, 42, 1);
        idle(45);

        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0:       val = int'($urandom_range(0, 198)) - 99;
                1:       val = int'($signed(16'($urandom)));
                2:       val = int'($urandom_range(0, 19998)) - 9999;
                default: begin
                    s4  = int'($urandom_range(0, 3));
                    val = (s4 == 0) ? -32768 : (s4 == 1) ? 32767 : (s4 == 2) ? 0 : -1;
                end
            endcase
            dp = int'($urandom_range(0, 6));
            cyc(1'b1, val, dp);
            idle(int'($urandom_range(15, 40)));
        end
        idle(45);

        cyc(1'b1, 4321, 0); idle(45);
        cyc(1'b1, -321, 1); idle(6);
        @(posedge iCLK);
        #2 iRST = 1'b1;
        exp_q.delete();
        free_at = 0;
        #1;
        check("arst_oBUSY", oBUSY, 0);
        check("arst_oDIG", oDIG, 1);
        check("arst_oNUM", oNUM, 0);
        check("arst_oOVF", oOVF, 0);
        @(posedge iCLK);
        #2 iRST = 1'b0;
        cyc(1'b1, 56, 0); idle(50);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
